id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS core, with load-use hazard detection and bubble insertion.
- Downstream, it directly feeds the EX-stage forwarding logic: ex_rs, ex_rt, ex_rw (destination) and ex_reg_write.
- Upstream, it drives the PC and IF/ID write enables.
- Also accepts a branch flush from MEM and a hold from a busy EX unit, and keeps a saturating load-use stall counter.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/id_ex_stage_hazard_detect.sv | 32 +++
 rtl/id_ex_stage.sv | 155 +++++++++++++++
 tb/tb_id_ex_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline: ALU op encodings, register
// zero and the decoded control bundle carried from ID into EX.
package mips_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_LUI = 4'd10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection against the instruction sitting in EX, and the
// resulting front-end write enables. Purely combinational.
module hazard_detect
  import mips_pkg::*;
(
  input  logic       rst,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rt,
  input  logic       flush,
  input  logic       ex_hold,
  output logic       load_use,
  output logic       pc_write,
  output logic       ifid_write
);

  logic rt_match;
  logic fe_en;

  always_comb begin
    rt_match   = (ex_rt == id_rs) || (id_use_rt && (ex_rt == id_rt));
    load_use   = !rst && ex_valid && ex_mem_read && (ex_rt != REG_ZERO) && rt_match;
    // A taken branch must always redirect the PC, even against hold or a hazard.
    fe_en      = rst || flush || !(ex_hold || load_use);
    pc_write   = fe_en;
    ifid_write = fe_en;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// EX hold and a saturating count of inserted load-use bubbles.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rt,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_alu_src,
  input  logic [3:0]       id_alu_op,
  input  logic [DW-1:0]    id_bus_a,
  input  logic [DW-1:0]    id_bus_b,
  input  logic [DW-1:0]    id_imm,
  input  logic [DW-1:0]    id_pc4,
  input  logic             flush,
  input  logic             ex_hold,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_rw,
  output logic             ex_valid,
  output logic             ex_reg_dst,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_alu_src,
  output logic [3:0]       ex_alu_op,
  output logic [DW-1:0]    ex_bus_a,
  output logic [DW-1:0]    ex_bus_b,
  output logic [DW-1:0]    ex_imm,
  output logic [DW-1:0]    ex_pc4,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             load_use,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_t            id_ctrl;
  ctrl_t            ctrl_d, ctrl_q;
  logic             valid_d, valid_q;
  logic [4:0]       rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [DW-1:0]    bus_a_d, bus_a_q, bus_b_d, bus_b_q;
  logic [DW-1:0]    imm_d, imm_q, pc4_d, pc4_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  hazard_detect u_hazard (
    .rst        (rst),
    .ex_valid   (valid_q),
    .ex_mem_read(ctrl_q.mem_read),
    .ex_rt      (rt_q),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rt  (id_use_rt),
    .flush      (flush),
    .ex_hold    (ex_hold),
    .load_use   (load_use),
    .pc_write   (pc_write),
    .ifid_write (ifid_write)
  );

  always_comb begin
    id_ctrl = '{reg_dst: id_reg_dst, reg_write: id_reg_write, mem_read: id_mem_read,
                mem_write: id_mem_write, mem_to_reg: id_mem_to_reg,
                alu_src: id_alu_src, alu_op: id_alu_op};
    ctrl_d      = ctrl_q;
    valid_d     = valid_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    bus_a_d     = bus_a_q;
    bus_b_d     = bus_b_q;
    imm_d       = imm_q;
    pc4_d       = pc4_q;
    stall_cnt_d = stall_cnt_q;
    // Flush, bubble and normal load all capture the ID fields; only hold skips them.
    if (flush || !ex_hold) begin
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      bus_a_d = id_bus_a;
      bus_b_d = id_bus_b;
      imm_d   = id_imm;
      pc4_d   = id_pc4;
      if (flush || load_use) begin
        ctrl_d  = CTRL_NOP;
        valid_d = 1'b0;
        if (!flush && stall_cnt_q != {CNT_W{1'b1}}) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end else begin
        ctrl_d  = id_ctrl;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q      <= CTRL_NOP;
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      bus_a_q     <= '0;
      bus_b_q     <= '0;
      imm_q       <= '0;
      pc4_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      bus_a_q     <= bus_a_d;
      bus_b_q     <= bus_b_d;
      imm_q       <= imm_d;
      pc4_q       <= pc4_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    ex_rs         = rs_q;
    ex_rt         = rt_q;
    ex_rd         = rd_q;
    ex_rw         = ctrl_q.reg_dst ? rd_q : rt_q;
    ex_valid      = valid_q;
    ex_reg_dst    = ctrl_q.reg_dst;
    ex_reg_write  = ctrl_q.reg_write;
    ex_mem_read   = ctrl_q.mem_read;
    ex_mem_write  = ctrl_q.mem_write;
    ex_mem_to_reg = ctrl_q.mem_to_reg;
    ex_alu_src    = ctrl_q.alu_src;
    ex_alu_op     = ctrl_q.alu_op;
    ex_bus_a      = bus_a_q;
    ex_bus_b      = bus_b_q;
    ex_imm        = imm_q;
    ex_pc4        = pc4_q;
    stall_cnt     = stall_cnt_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic, checked
// against a behavioural model of the EX-side contents and the bubble count.
module tb_id_ex_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          id_use_rt, id_reg_dst, id_reg_write, id_mem_read;
  logic          id_mem_write, id_mem_to_reg, id_alu_src;
  logic [3:0]    id_alu_op;
  logic [DW-1:0] id_bus_a, id_bus_b, id_imm, id_pc4;
  logic          flush, ex_hold;

  logic [4:0]    ex_rs, ex_rt, ex_rd, ex_rw;
  logic          ex_valid, ex_reg_dst, ex_reg_write, ex_mem_read;
  logic          ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [3:0]    ex_alu_op;
  logic [DW-1:0] ex_bus_a, ex_bus_b, ex_imm, ex_pc4;
  logic          pc_write, ifid_write, load_use;
  logic [15:0]   stall_cnt;

  logic [4:0]    s_rs, s_rt, s_rd, s_rw;
  logic          s_valid, s_reg_dst, s_reg_write, s_mem_read;
  logic          s_mem_write, s_mem_to_reg, s_alu_src;
  logic [3:0]    s_alu_op;
  logic [DW-1:0] s_bus_a, s_bus_b, s_imm, s_pc4;
  logic          s_pc_write, s_ifid_write, s_load_use;
  logic [1:0]    s_stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_use_rt(id_use_rt),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_bus_a(id_bus_a), .id_bus_b(id_bus_b), .id_imm(id_imm),
    .id_pc4(id_pc4), .flush(flush), .ex_hold(ex_hold),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rw(ex_rw), .ex_valid(ex_valid),
    .ex_reg_dst(ex_reg_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_bus_a(ex_bus_a), .ex_bus_b(ex_bus_b), .ex_imm(ex_imm),
    .ex_pc4(ex_pc4), .pc_write(pc_write), .ifid_write(ifid_write), .load_use(load_use),
    .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.DW(DW), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_use_rt(id_use_rt),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_bus_a(id_bus_a), .id_bus_b(id_bus_b), .id_imm(id_imm),
    .id_pc4(id_pc4), .flush(flush), .ex_hold(ex_hold),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_rw(s_rw), .ex_valid(s_valid),
    .ex_reg_dst(s_reg_dst), .ex_reg_write(s_reg_write), .ex_mem_read(s_mem_read),
    .ex_mem_write(s_mem_write), .ex_mem_to_reg(s_mem_to_reg), .ex_alu_src(s_alu_src),
    .ex_alu_op(s_alu_op), .ex_bus_a(s_bus_a), .ex_bus_b(s_bus_b), .ex_imm(s_imm),
    .ex_pc4(s_pc4), .pc_write(s_pc_write), .ifid_write(s_ifid_write), .load_use(s_load_use),
    .stall_cnt(s_stall_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Model of what EX holds: one record for the instruction, plus bubble counts.
  typedef struct {
    bit       valid;
    bit       reg_dst, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    int       alu_op;
    int       rs, rt, rd;
    longint   bus_a, bus_b, imm, pc4;
    bit       fields_known;
  } ex_rec_t;

  ex_rec_t m;
  int      m_bubbles;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic ex_rec_t empty_rec();
    ex_rec_t r;
    r = '{default: 0};
    r.fields_known = 1;
    return r;
  endfunction

  function automatic bit model_hazard();
    bit reads;
    reads = (m.rt == int'(id_rs)) || (id_use_rt && m.rt == int'(id_rt));
    return m.valid && m.mem_read && m.rt != 0 && reads;
  endfunction

  function automatic ex_rec_t id_instr();
    ex_rec_t r;
    r.valid = 1; r.reg_dst = id_reg_dst; r.reg_write = id_reg_write;
    r.mem_read = id_mem_read; r.mem_write = id_mem_write; r.mem_to_reg = id_mem_to_reg;
    r.alu_src = id_alu_src; r.alu_op = int'(id_alu_op);
    r.rs = int'(id_rs); r.rt = int'(id_rt); r.rd = int'(id_rd);
    r.bus_a = longint'(id_bus_a); r.bus_b = longint'(id_bus_b);
    r.imm = longint'(id_imm); r.pc4 = longint'(id_pc4);
    r.fields_known = 1;
    return r;
  endfunction

  task automatic check_comb();
    bit lu, fe;
    #1;
    lu = model_hazard();
    fe = flush || !(ex_hold || lu);
    check("load_use", 64'(load_use), 64'(lu));
    check("pc_write", 64'(pc_write), 64'(fe));
    check("ifid_write", 64'(ifid_write), 64'(fe));
    check("sat_load_use", 64'(s_load_use), 64'(lu));
  endtask

  task automatic check_regs();
    int rw;
    check("ex_valid", 64'(ex_valid), 64'(m.valid));
    check("ex_reg_write", 64'(ex_reg_write), 64'(m.reg_write));
    check("ex_mem_read", 64'(ex_mem_read), 64'(m.mem_read));
    check("ex_ctrl_other", {ex_reg_dst, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op},
          {m.reg_dst, m.mem_write, m.mem_to_reg, m.alu_src, 4'(m.alu_op)});
    check("stall_cnt", 64'(stall_cnt), 64'(m_bubbles > 65535 ? 65535 : m_bubbles));
    check("sat_stall_cnt", 64'(s_stall_cnt), 64'(m_bubbles > 3 ? 3 : m_bubbles));
    if (m.fields_known) begin
      rw = m.reg_dst ? m.rd : m.rt;
      check("ex_regs", {ex_rs, ex_rt, ex_rd}, {5'(m.rs), 5'(m.rt), 5'(m.rd)});
      check("ex_rw", 64'(ex_rw), 64'(rw));
      check("ex_bus_a", 64'(ex_bus_a), 64'(m.bus_a));
      check("ex_bus_b", 64'(ex_bus_b), 64'(m.bus_b));
      check("ex_imm", 64'(ex_imm), 64'(m.imm));
      check("ex_pc4", 64'(ex_pc4), 64'(m.pc4));
    end
  endtask

  // One clock: model evaluates the rules on the pre-edge state, then compare.
  task automatic step();
    bit lu;
    ex_rec_t nxt;
    lu = model_hazard();
    @(posedge clk);
    if (rst) begin
      m = empty_rec(); m_bubbles = 0;
    end else if (flush) begin
      m = empty_rec(); m.fields_known = 0;
    end else if (!ex_hold) begin
      nxt = id_instr();
      if (lu) begin
        nxt.valid = 0; nxt.reg_dst = 0; nxt.reg_write = 0; nxt.mem_read = 0;
        nxt.mem_write = 0; nxt.mem_to_reg = 0; nxt.alu_src = 0; nxt.alu_op = 0;
        m_bubbles++;
      end
      m = nxt;
    end
    #1;
    check_regs();
  endtask

  task automatic set_id(input int rs, input int rt, input int rd, input bit use_rt,
                        input bit reg_dst, input bit reg_write, input bit mem_read);
    id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd); id_use_rt = use_rt;
    id_reg_dst = reg_dst; id_reg_write = reg_write; id_mem_read = mem_read;
    id_mem_write = 0; id_mem_to_reg = mem_read; id_alu_src = mem_read;
    id_alu_op = 4'd0;
    id_bus_a = $urandom; id_bus_b = $urandom; id_imm = $urandom; id_pc4 = $urandom;
  endtask

  task automatic rand_id();
    id_rs = 5'($urandom_range(9, 0)); id_rt = 5'($urandom_range(9, 0));
    id_rd = 5'($urandom); id_use_rt = 1'($urandom);
    id_reg_dst = 1'($urandom); id_reg_write = 1'($urandom);
    id_mem_read = ($urandom_range(4, 0) < 2); id_mem_write = 1'($urandom);
    id_mem_to_reg = 1'($urandom); id_alu_src = 1'($urandom);
    id_alu_op = 4'($urandom);
    id_bus_a = $urandom; id_bus_b = $urandom; id_imm = $urandom; id_pc4 = $urandom;
  endtask

  logic [4:0]  fr_rs;
  logic [31:0] fr_a;
  logic [15:0] cnt_before;

  initial begin
    m = empty_rec(); m_bubbles = 0;
    rst = 1; flush = 0; ex_hold = 0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    #12;
    check("reset_valid", 64'(ex_valid), 64'd0);
    check("reset_cnt", 64'(stall_cnt), 64'd0);
    check("reset_pc_write", 64'(pc_write), 64'd1);
    @(negedge clk); rst = 0;

    // Normal flow.
    set_id(3, 4, 5, 1, 1, 1, 0); id_bus_a = 32'h11;
    check_comb();
    check("normal_pc_write", 64'(pc_write), 64'd1);
    step();
    check("normal_rw", 64'(ex_rw), 64'd5);
    check("normal_valid", 64'(ex_valid), 64'd1);
    check("normal_bus_a", 64'(ex_bus_a), 64'h11);

    // Load-use: lw rt=8, then consumer with rs=8.
    set_id(1, 8, 0, 0, 0, 1, 1); check_comb(); step();
    set_id(8, 2, 9, 1, 1, 1, 0); check_comb();
    check("lu_detect", 64'(load_use), 64'd1);
    check("lu_pc_write", 64'(pc_write), 64'd0);
    check("lu_ifid_write", 64'(ifid_write), 64'd0);
    step();
    check("lu_bubble_wr", 64'(ex_reg_write), 64'd0);
    check("lu_bubble_valid", 64'(ex_valid), 64'd0);
    check("lu_cnt", 64'(stall_cnt), 64'd1);
    check_comb();
    check("lu_released", 64'(load_use), 64'd0);
    step();
    check("lu_advance_valid", 64'(ex_valid), 64'd1);
    check("lu_advance_rs", 64'(ex_rs), 64'd8);

    // No false hazard: rt=0, and rt match without use_rt.
    set_id(1, 0, 0, 0, 0, 1, 1); check_comb(); step();
    set_id(0, 0, 3, 1, 1, 1, 0); check_comb();
    check("nofalse_zero", 64'(load_use), 64'd0);
    step();
    set_id(1, 8, 0, 0, 0, 1, 1); check_comb(); step();
    set_id(1, 8, 3, 0, 1, 1, 0); check_comb();
    check("nofalse_use_rt", 64'(load_use), 64'd0);
    step();

    // Flush beats hold and load-use.
    set_id(1, 8, 0, 0, 0, 1, 1); check_comb(); step();
    cnt_before = stall_cnt;
    set_id(8, 8, 3, 1, 1, 1, 0); flush = 1; ex_hold = 1; check_comb();
    check("flush_pc_write", 64'(pc_write), 64'd1);
    step();
    flush = 0; ex_hold = 0;
    check("flush_valid", 64'(ex_valid), 64'd0);
    check("flush_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_reg_dst}, 64'd0);
    check("flush_cnt", 64'(stall_cnt), 64'(cnt_before));

    // Hold for three cycles, including a pending load-use.
    set_id(1, 8, 0, 0, 0, 1, 1); check_comb(); step();
    fr_rs = ex_rs; fr_a = ex_bus_a;
    cnt_before = stall_cnt;
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id(); id_rs = 5'd8; check_comb();
      check("hold_pc_write", 64'(pc_write), 64'd0);
      step();
      check("hold_rs", 64'(ex_rs), 64'(fr_rs));
      check("hold_bus_a", 64'(ex_bus_a), 64'(fr_a));
      check("hold_cnt", 64'(stall_cnt), 64'(cnt_before));
    end
    ex_hold = 0; check_comb();
    check("hold_release_lu", 64'(load_use), 64'd1);
    step();

    // Five more bubbles: the 2-bit counter pins at 3.
    for (int i = 0; i < 5; i++) begin
      set_id(2, 8, 0, 0, 0, 1, 1); check_comb(); step();
      set_id(8, 1, 4, 0, 1, 1, 0); check_comb(); step();
    end
    check("sat_pinned", 64'(s_stall_cnt), 64'd3);

    // Async reset mid-cycle with reg_write live in EX.
    set_id(3, 4, 6, 0, 1, 1, 0); check_comb(); step();
    ex_hold = 1;
    #3 rst = 1; #1;
    check("areset_reg_write", 64'(ex_reg_write), 64'd0);
    check("areset_valid", 64'(ex_valid), 64'd0);
    check("areset_cnt", 64'(stall_cnt), 64'd0);
    check("areset_pc_write", 64'(pc_write), 64'd1);
    m = empty_rec(); m_bubbles = 0;
    step();
    @(negedge clk); rst = 0; ex_hold = 0;
    set_id(7, 9, 11, 1, 0, 1, 0); check_comb(); step();
    check("post_reset_load", 64'(ex_valid), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rand_id();
      flush   = ($urandom_range(9, 0) == 0);
      ex_hold = ($urandom_range(5, 0) == 0);
      check_comb();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
